io_ctrl_mmio: RTL and testbench

Parametrised memory-mapped IO controller placed between the CPU data port, DMem and the board IO.
- Decodes a word-addressed IO window.
- Steers writes either to DMem or to IO registers.
- Muxes read data back to the CPU.
- Scans an N-digit 7-segment display.
- Synchronises and debounces M push-switches, with sticky edge flags and a free-running cycle counter.

---
 rtl/io_ctrl_mmio.sv | 151 +++++++++++++++
 tb/tb_io_ctrl_mmio.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_ctrl_mmio.sv
// MMIO controller: IO window decode, DMem write steering, zero-latency read mux,
// multiplexed 7-seg scan, and debounced switches with sticky rising-edge flags.
module io_ctrl_mmio #(
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    ADDR_WIDTH      = 16,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE         = 16'hFF00,
  parameter int                    NUM_DIGITS      = 8,
  parameter int                    NUM_SWITCHES    = 3,
  parameter int                    LAMP_WIDTH      = 8,
  parameter int                    DEBOUNCE_CYCLES = 16,
  parameter int                    SCAN_DIVIDE     = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   addr_from_cpu,
  input  logic [DATA_WIDTH-1:0]   data_from_cpu,
  input  logic                    we_from_cpu,
  input  logic [DATA_WIDTH-1:0]   data_from_dmem,
  output logic                    dmem_wr_enable,
  output logic [DATA_WIDTH-1:0]   data_to_cpu,
  input  logic [NUM_SWITCHES-1:0] sw_in,
  output logic [7:0]              led,
  output logic [NUM_DIGITS-1:0]   gate,
  output logic [LAMP_WIDTH-1:0]   lamp
);

  localparam int DISP_W = 4 * NUM_DIGITS;
  localparam int CW     = $clog2(DEBOUNCE_CYCLES);
  localparam int PW     = (SCAN_DIVIDE > 1) ? $clog2(SCAN_DIVIDE) : 1;
  localparam int IW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  function automatic logic [6:0] hex7seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Subtract-then-check-high-bits avoids overflow when IO_BASE sits at the top of the map.
  logic [ADDR_WIDTH-1:0] io_off_full;
  logic [2:0]            io_off;
  logic                  io_hit;
  logic                  io_wr;

  assign io_off_full = addr_from_cpu - IO_BASE;
  assign io_off      = io_off_full[2:0];
  assign io_hit      = (addr_from_cpu >= IO_BASE) && (io_off_full[ADDR_WIDTH-1:3] == '0);
  assign io_wr       = we_from_cpu & io_hit;

  assign dmem_wr_enable = we_from_cpu & ~io_hit;

  logic [DISP_W-1:0]       disp_q, disp_d;
  logic [LAMP_WIDTH-1:0]   lamp_q, lamp_d;
  logic [NUM_SWITCHES-1:0] level_q, level_d;
  logic [NUM_SWITCHES-1:0] edge_q, edge_d;
  logic [DATA_WIDTH-1:0]   cyc_q, cyc_d;
  logic [NUM_SWITCHES-1:0] sync1_q, sync2_q;
  logic [CW-1:0]           cnt_q [NUM_SWITCHES];
  logic [CW-1:0]           cnt_d [NUM_SWITCHES];
  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   io_rdata;
  logic [NUM_SWITCHES-1:0] edge_clr;

  always_comb begin
    io_rdata = '0;
    case (io_off)
      3'd0:    io_rdata[DISP_W-1:0]       = disp_q;
      3'd1:    io_rdata[LAMP_WIDTH-1:0]   = lamp_q;
      3'd2:    io_rdata[NUM_SWITCHES-1:0] = level_q;
      3'd3:    io_rdata[NUM_SWITCHES-1:0] = edge_q;
      3'd4:    io_rdata                   = cyc_q;
      default: io_rdata                   = '0;
    endcase
  end

  assign data_to_cpu = io_hit ? io_rdata : data_from_dmem;

  always_comb begin
    disp_d = disp_q;
    lamp_d = lamp_q;
    cyc_d  = cyc_q + DATA_WIDTH'(1);
    if (io_wr && io_off == 3'd0) disp_d = data_from_cpu[DISP_W-1:0];
    if (io_wr && io_off == 3'd1) lamp_d = data_from_cpu[LAMP_WIDTH-1:0];
    if (io_wr && io_off == 3'd4) cyc_d  = data_from_cpu;
  end

  // A level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < NUM_SWITCHES; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_d[i]   = '0;
        level_d[i] = ~level_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Set is OR-ed after the clear so a simultaneous new edge survives the W1C.
  assign edge_clr = (io_wr && io_off == 3'd3) ? data_from_cpu[NUM_SWITCHES-1:0] : '0;
  assign edge_d   = (edge_q & ~edge_clr) | (level_d & ~level_q);

  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIVIDE - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_q  <= '0;
      lamp_q  <= '0;
      level_q <= '0;
      edge_q  <= '0;
      cyc_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      for (int i = 0; i < NUM_SWITCHES; i++) cnt_q[i] <= '0;
    end else begin
      disp_q  <= disp_d;
      lamp_q  <= lamp_d;
      level_q <= level_d;
      edge_q  <= edge_d;
      cyc_q   <= cyc_d;
      sync1_q <= sw_in;
      sync2_q <= sync1_q;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      for (int i = 0; i < NUM_SWITCHES; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign gate = NUM_DIGITS'(1) << idx_q;
  assign led  = {1'b0, hex7seg(disp_q[4*idx_q +: 4])};
  assign lamp = lamp_q;

endmodule

// File: tb/tb_io_ctrl_mmio.sv
// Scoreboard bench for io_ctrl_mmio: stimulus queues expected outputs, a negedge monitor checks them.
module tb_io_ctrl_mmio;
  localparam int         DW = 32;
  localparam int         AW = 16;
  localparam logic [15:0] BASE = 16'hFF00;
  localparam int         ND = 3;
  localparam int         NS = 3;
  localparam int         LW = 8;
  localparam int         DB = 16;
  localparam int         SD = 4;

  localparam int K_DATA = 0, K_DWE = 1, K_LED = 2, K_GATE = 3, K_LAMP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] addr_from_cpu;
  logic [DW-1:0] data_from_cpu;
  logic          we_from_cpu;
  logic [DW-1:0] data_from_dmem;
  logic          dmem_wr_enable;
  logic [DW-1:0] data_to_cpu;
  logic [NS-1:0] sw_in;
  logic [7:0]    led;
  logic [ND-1:0] gate;
  logic [LW-1:0] lamp;

  io_ctrl_mmio #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IO_BASE(BASE), .NUM_DIGITS(ND),
    .NUM_SWITCHES(NS), .LAMP_WIDTH(LW), .DEBOUNCE_CYCLES(DB), .SCAN_DIVIDE(SD)
  ) dut (
    .clk(clk), .rst(rst),
    .addr_from_cpu(addr_from_cpu), .data_from_cpu(data_from_cpu),
    .we_from_cpu(we_from_cpu), .data_from_dmem(data_from_dmem),
    .dmem_wr_enable(dmem_wr_enable), .data_to_cpu(data_to_cpu),
    .sw_in(sw_in), .led(led), .gate(gate), .lamp(lamp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   ncyc  = 0;

  // Clock edges seen out of reset: drives the scan-phase and cycle-counter expectations.
  always @(posedge clk or negedge rst) begin
    if (!rst) ncyc = 0;
    else      ncyc = ncyc + 1;
  end

  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = sbq.pop_front();
      case (e.kind)
        K_DATA:  act = data_to_cpu;
        K_DWE:   act = {31'b0, dmem_wr_enable};
        K_LED:   act = {24'b0, led};
        K_GATE:  act = {29'b0, gate};
        default: act = {24'b0, lamp};
      endcase
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, act, e.exp);
      end
    end
  end

  task automatic expect_out(input int kind, input logic [31:0] v, input string nm);
    exp_t e;
    e.kind = kind;
    e.exp  = v;
    e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we_from_cpu   = we;
    addr_from_cpu = a;
    data_from_cpu = d;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [31:0] v, input string nm);
    bus(1'b0, a, '0);
    expect_out(K_DATA, v, nm);
    tick();
  endtask

  task automatic io_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input string nm);
    bus(1'b1, a, d);
    expect_out(K_DWE, 0, nm);
    tick();
    bus(1'b0, a, '0);
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 12 && (ncyc % 12) != p; i++) tick();
  endtask

  logic [2:0] gtab [4];
  logic [7:0] ltab [4];

  initial begin
    gtab = '{3'b001, 3'b010, 3'b100, 3'b001};
    ltab = '{8'h6D, 8'h77, 8'h3F, 8'h6D};
    sw_in          = '0;
    data_from_dmem = 32'hDEAD_BEEF;
    bus(1'b0, BASE, '0);
    #2;
    expect_out(K_DATA, 0, "rst_disp");
    expect_out(K_GATE, 1, "rst_gate");
    expect_out(K_LED, 32'h3F, "rst_led");
    expect_out(K_LAMP, 0, "rst_lamp");
    expect_out(K_DWE, 0, "rst_dwe");
    tick();
    tick();
    rst = 1'b1;

    io_wr(BASE, 32'h0000_00A5, "disp_wr_dwe");
    rd(BASE, 32'hA5, "disp_rd");
    wait_phase(0);
    expect_out(K_GATE, 1, "dig0_gate");
    expect_out(K_LED, 32'h6D, "dig0_led");
    wait_phase(4);
    expect_out(K_GATE, 2, "dig1_gate");
    expect_out(K_LED, 32'h77, "dig1_led");
    wait_phase(8);
    expect_out(K_LED, 32'h3F, "dig2_led");

    bus(1'b1, 16'h0010, 32'h1234);
    expect_out(K_DWE, 1, "dmem_wr_dwe");
    tick();
    data_from_dmem = 32'h0000_1234;
    bus(1'b0, 16'h0010, '0);
    expect_out(K_DWE, 0, "dmem_idle_dwe");
    expect_out(K_DATA, 32'h1234, "dmem_rd");
    tick();
    data_from_dmem = 32'hDEAD_BEEF;

    bus(1'b1, 16'hFEFF, 32'h1);
    expect_out(K_DWE, 1, "below_win_dwe");
    tick();
    bus(1'b1, 16'hFF08, 32'h1);
    expect_out(K_DWE, 1, "above_win_dwe");
    expect_out(K_DATA, 32'hDEAD_BEEF, "above_win_rd");
    tick();
    io_wr(BASE + 16'd7, 32'hFFFF_FFFF, "rsv7_wr_dwe");
    rd(BASE + 16'd7, 0, "rsv7_rd");
    rd(BASE + 16'd5, 0, "rsv5_rd");

    io_wr(BASE + 16'd1, 32'h0000_005A, "lamp_wr_dwe");
    expect_out(K_LAMP, 32'h5A, "lamp_out");
    rd(BASE + 16'd1, 32'h5A, "lamp_rd");
    bus(1'b0, BASE + 16'd4, '0);
    expect_out(K_DATA, 32'(ncyc), "cycle_free");
    tick();

    sw_in = 3'b001;
    repeat (DB + 1) tick();
    rd(BASE + 16'd2, 0, "sw_level_early");
    rd(BASE + 16'd2, 1, "sw_level_rise");
    rd(BASE + 16'd3, 1, "sw_edge_rise");
    sw_in = 3'b000;
    repeat (5) tick();
    sw_in = 3'b001;
    rd(BASE + 16'd2, 1, "glitch_level_a");
    repeat (DB + 2) tick();
    rd(BASE + 16'd2, 1, "glitch_level_b");

    sw_in = 3'b000;
    repeat (DB + 2) tick();
    rd(BASE + 16'd2, 0, "sw_level_fall");
    rd(BASE + 16'd3, 1, "sw_edge_sticky");
    sw_in = 3'b001;
    repeat (DB + 1) tick();
    io_wr(BASE + 16'd3, 32'h1, "w1c_race_dwe");
    rd(BASE + 16'd3, 1, "w1c_set_wins");
    rd(BASE + 16'd2, 1, "sw_level_rise2");
    io_wr(BASE + 16'd3, 32'h1, "w1c_dwe");
    rd(BASE + 16'd3, 0, "w1c_clear");

    io_wr(BASE + 16'd4, 32'hFFFF_FFFE, "cyc_wr_dwe");
    rd(BASE + 16'd4, 32'hFFFF_FFFE, "cyc_load");
    rd(BASE + 16'd4, 32'hFFFF_FFFF, "cyc_inc");
    rd(BASE + 16'd4, 32'h0000_0000, "cyc_wrap");

    bus(1'b0, BASE, '0);
    wait_phase(0);
    for (int i = 0; i < 13; i++) begin
      expect_out(K_GATE, 32'(gtab[i/4]), "scan_gate");
      expect_out(K_LED, 32'(ltab[i/4]), "scan_led");
      tick();
    end

    wait_phase(6);
    rst = 1'b0;
    expect_out(K_GATE, 1, "arst_gate");
    expect_out(K_LED, 32'h3F, "arst_led");
    expect_out(K_LAMP, 0, "arst_lamp");
    expect_out(K_DATA, 0, "arst_disp");
    tick();
    tick();
    rst = 1'b1;
    expect_out(K_GATE, 1, "post_rst_gate");
    rd(BASE + 16'd3, 0, "post_rst_edge");
    tick();
    tick();
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d left want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
